// File: rtl/keypad_time_entry.sv
// Keypad digit-entry stage: debounces the encoder strobe, shifts accepted BCD
// digits into an MM:SS entry register and hands valid entries to the timer.
module keypad_time_entry #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  BCD,
  input  logic        LOAD_N,
  input  logic        ENTRY_EN,
  input  logic        CLEAR,
  input  logic        START,
  output logic [15:0] DIGITS,
  output logic [2:0]  DIGIT_CNT,
  output logic        VALID,
  output logic        KEY_ACK,
  output logic        LOAD_TIMER,
  output logic        ERR
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } key_state_e;

  key_state_e state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] bcd_q, bcd_nxt;
  logic       accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      bcd_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bcd_q <= bcd_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bcd_nxt   = bcd_q;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!LOAD_N) begin
          state_nxt = S_DEBOUNCE;
          cnt_nxt   = 8'd1;
          bcd_nxt   = BCD;
        end
      end
      S_DEBOUNCE: begin
        if (LOAD_N) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (BCD != bcd_q) begin
          // Digit changed while settling: restart the window on the new code.
          cnt_nxt = 8'd1;
          bcd_nxt = BCD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HELD;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_HELD: begin
        if (LOAD_N) begin
          state_nxt = S_RELEASE;
          cnt_nxt   = 8'd1;
        end
      end
      S_RELEASE: begin
        // A low sample here is contact bounce, not a fresh press.
        if (!LOAD_N) begin
          state_nxt = S_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign VALID = (DIGITS != 16'h0000) && (DIGITS[7:4] <= 4'd5);

  // Priority: reset, clear, start, then digit shift.
  always_ff @(posedge CLK) begin
    KEY_ACK    <= 1'b0;
    LOAD_TIMER <= 1'b0;
    ERR        <= 1'b0;
    if (RST) begin
      DIGITS    <= '0;
      DIGIT_CNT <= '0;
    end else if (CLEAR) begin
      DIGITS    <= '0;
      DIGIT_CNT <= '0;
    end else if (START) begin
      if (VALID) LOAD_TIMER <= 1'b1;
      else       ERR        <= 1'b1;
    end else if (accept && ENTRY_EN && (DIGIT_CNT < 3'd4) && (bcd_q <= 4'd9)) begin
      DIGITS    <= {DIGITS[11:0], bcd_q};
      DIGIT_CNT <= DIGIT_CNT + 3'd1;
      KEY_ACK   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Scoreboard bench for keypad_time_entry: stimulus pushes expected pulses,
// a negedge monitor pops and compares them, including the edge they land on.
module tb_keypad_time_entry;

  localparam int N = 4;
  localparam logic [2:0] K_ACK  = 3'b100;
  localparam logic [2:0] K_LOAD = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b001;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  BCD;
  logic        LOAD_N;
  logic        ENTRY_EN;
  logic        CLEAR;
  logic        START;
  logic [15:0] DIGITS;
  logic [2:0]  DIGIT_CNT;
  logic        VALID;
  logic        KEY_ACK;
  logic        LOAD_TIMER;
  logic        ERR;

  keypad_time_entry #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BCD        (BCD),
    .LOAD_N     (LOAD_N),
    .ENTRY_EN   (ENTRY_EN),
    .CLEAR      (CLEAR),
    .START      (START),
    .DIGITS     (DIGITS),
    .DIGIT_CNT  (DIGIT_CNT),
    .VALID      (VALID),
    .KEY_ACK    (KEY_ACK),
    .LOAD_TIMER (LOAD_TIMER),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  kind;
    logic [15:0] digits;
    logic [2:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge CLK) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_n);
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input int delay,
                              input logic [15:0] d, input logic [2:0] c);
    exp_t e;
    e.kind   = kind;
    e.digits = d;
    e.cnt    = c;
    e.cyc    = edge_n + delay;
    sb_q.push_back(e);
  endtask

  // Monitor: any output pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    logic [2:0] kind;
    exp_t e;
    kind = {KEY_ACK, LOAD_TIMER, ERR};
    if (kind != 3'b000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'(kind), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind",   32'(kind),      32'(e.kind));
        check("pulse_edge",   32'(edge_n),    32'(e.cyc));
        check("pulse_digits", 32'(DIGITS),    32'(e.digits));
        check("pulse_cnt",    32'(DIGIT_CNT), 32'(e.cnt));
      end
    end
  end

  // All tasks are entered and left just after a falling edge.
  task automatic hold(input logic ln, input int n);
    LOAD_N = ln;
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] d, input logic ack,
                       input logic [15:0] exp_d, input logic [2:0] exp_c);
    if (ack) expect_pulse(K_ACK, N, exp_d, exp_c);
    BCD = d;
    hold(1'b0, 6);
    hold(1'b1, 6);
  endtask

  task automatic pulse_start(input logic [2:0] kind, input logic [15:0] exp_d,
                             input logic [2:0] exp_c);
    expect_pulse(kind, 1, exp_d, exp_c);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic pulse_clear();
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
  endtask

  task automatic check_entry(input string name, input logic [15:0] d,
                             input logic [2:0] c, input logic v);
    check({name, "_digits"}, 32'(DIGITS), 32'(d));
    check({name, "_cnt"},    32'(DIGIT_CNT), 32'(c));
    check({name, "_valid"},  32'(VALID), 32'(v));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; BCD = 4'd0; LOAD_N = 1'b1; ENTRY_EN = 1'b1;
    CLEAR = 1'b0; START = 1'b0;
    repeat (3) @(negedge CLK);
    check_entry("reset", 16'h0000, 3'd0, 1'b0);
    check("reset_outs", 32'({KEY_ACK, LOAD_TIMER, ERR}), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Basic entry and a valid start.
    press(4'd1, 1'b1, 16'h0001, 3'd1);
    press(4'd3, 1'b1, 16'h0013, 3'd2);
    press(4'd0, 1'b1, 16'h0130, 3'd3);
    check_entry("basic", 16'h0130, 3'd3, 1'b1);
    pulse_start(K_LOAD, 16'h0130, 3'd3);
    check_entry("after_load", 16'h0130, 3'd3, 1'b1);
    pulse_clear();
    check_entry("clear1", 16'h0000, 3'd0, 1'b0);
    pulse_start(K_ERR, 16'h0000, 3'd0);

    // Press bounce (2 low, 1 high, then held), followed by a release bounce.
    expect_pulse(K_ACK, 7, 16'h0005, 3'd1);
    BCD = 4'd5;
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 6);
    hold(1'b1, 2);
    hold(1'b0, 3);
    hold(1'b1, 6);
    check_entry("bounce", 16'h0005, 3'd1, 1'b1);
    pulse_clear();

    // Overflow: fifth digit is dropped.
    press(4'd1, 1'b1, 16'h0001, 3'd1);
    press(4'd2, 1'b1, 16'h0012, 3'd2);
    press(4'd3, 1'b1, 16'h0123, 3'd3);
    press(4'd4, 1'b1, 16'h1234, 3'd4);
    press(4'd5, 1'b0, 16'h0000, 3'd0);
    check_entry("overflow", 16'h1234, 3'd4, 1'b1);
    pulse_clear();
    check_entry("clear2", 16'h0000, 3'd0, 1'b0);

    // Seconds tens of 7 is rejected.
    press(4'd1, 1'b1, 16'h0001, 3'd1);
    press(4'd7, 1'b1, 16'h0017, 3'd2);
    press(4'd5, 1'b1, 16'h0175, 3'd3);
    check_entry("invalid", 16'h0175, 3'd3, 1'b0);
    pulse_start(K_ERR, 16'h0175, 3'd3);
    check_entry("after_err", 16'h0175, 3'd3, 1'b0);
    pulse_clear();

    // Accept coincident with CLEAR: the shift is discarded.
    press(4'd1, 1'b1, 16'h0001, 3'd1);
    BCD = 4'd2;
    LOAD_N = 1'b0;
    repeat (N - 1) @(negedge CLK);
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
    repeat (2) @(negedge CLK);
    hold(1'b1, 6);
    check_entry("accept_clear", 16'h0000, 3'd0, 1'b0);

    // Accept coincident with START: the timer loads the pre-shift value.
    press(4'd1, 1'b1, 16'h0001, 3'd1);
    press(4'd3, 1'b1, 16'h0013, 3'd2);
    expect_pulse(K_LOAD, N, 16'h0013, 3'd2);
    BCD = 4'd0;
    LOAD_N = 1'b0;
    repeat (N - 1) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (2) @(negedge CLK);
    hold(1'b1, 6);
    check_entry("accept_start", 16'h0013, 3'd2, 1'b1);

    // Entry disabled, then an out-of-range code.
    ENTRY_EN = 1'b0;
    press(4'd9, 1'b0, 16'h0000, 3'd0);
    ENTRY_EN = 1'b1;
    check_entry("entry_dis", 16'h0013, 3'd2, 1'b1);
    press(4'hA, 1'b0, 16'h0000, 3'd0);
    check_entry("bcd_range", 16'h0013, 3'd2, 1'b1);

    // Reset mid-debounce with the key still held: re-accepted afterwards.
    BCD = 4'd7;
    LOAD_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_entry("mid_reset", 16'h0000, 3'd0, 1'b0);
    check("mid_reset_outs", 32'({KEY_ACK, LOAD_TIMER, ERR}), 32'd0);
    expect_pulse(K_ACK, N, 16'h0007, 3'd1);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    hold(1'b1, 6);
    check_entry("post_reset", 16'h0007, 3'd1, 1'b1);

    repeat (4) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_time_entry.md
# keypad_time_entry

Sequential digit-entry stage directly downstream of the keypad decimal-to-BCD encoder. It debounces the encoder's active-low key-valid strobe (`LOAD_N`) and accepts exactly one digit per physical key press. Accepted BCD digits are shifted into a 4-digit MM:SS entry register. On request, it validates the entry and hands it to the countdown timer with a one-cycle load pulse.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4, range 2..255. Consecutive identical samples required to accept a press or a release.

Ports:
- `CLK`, input, 1 bit. System clock. All state changes on the rising edge.
- `RST`, input, 1 bit. Synchronous, active-high reset.
- `BCD`, input, 4 bits. Key digit from the encoder (0..9).
- `LOAD_N`, input, 1 bit. Encoder key-valid strobe, active low.
- `ENTRY_EN`, input, 1 bit. Controller permits digit entry (oven idle).
- `CLEAR`, input, 1 bit. Clears the entry register.
- `START`, input, 1 bit. Requests transfer of the entry to the timer.
- `DIGITS`, output, 16 bits. {min tens, min units, sec tens, sec units}, 4 bits BCD each.
- `DIGIT_CNT`, output, 3 bits. Number of digits entered, 0..4.
- `VALID`, output, 1 bit. Combinational: `DIGITS != 0` and sec-tens ≤ 5.
- `KEY_ACK`, output, 1 bit. One-cycle pulse when a digit is shifted in.
- `LOAD_TIMER`, output, 1 bit. One-cycle pulse; the timer captures `DIGITS` on it.
- `ERR`, output, 1 bit. One-cycle pulse when `START` is rejected.

## Operation
Key FSM. States: IDLE, DEBOUNCE, HELD, RELEASE. There is an internal counter `cnt` and a captured digit `bcd_q`.
- IDLE: `LOAD_N`=0 → DEBOUNCE, `cnt`=1, `bcd_q`=`BCD`.
- DEBOUNCE:
  - `LOAD_N`=1 → IDLE.
  - `LOAD_N`=0 with `BCD`≠`bcd_q` → stay, `cnt`=1, recapture `bcd_q`.
  - `cnt`==`DEBOUNCE_CYCLES`−1 → press accepted, go to HELD.
  - Otherwise `cnt`++.
- HELD: `LOAD_N`=1 → RELEASE, `cnt`=1.
- RELEASE:
  - `LOAD_N`=0 → HELD. A bounce does not count as a new press.
  - `cnt`==`DEBOUNCE_CYCLES`−1 → IDLE.
  - Otherwise `cnt`++.
- A press therefore requires a full debounced release before the next press is accepted. A held key produces one digit only.

Entry register. Conditions are evaluated in this priority order each cycle:
1. `RST`: everything is cleared (see Timing).
2. `CLEAR`: `DIGITS`=0, `DIGIT_CNT`=0. A same-cycle accept or `START` is discarded; the key FSM still advances.
3. `START`:
   - If `VALID`: `LOAD_TIMER`=1 for one cycle. `DIGITS`/`DIGIT_CNT` are unchanged.
   - If not `VALID`: `ERR`=1 for one cycle, with no other effect.
   - A same-cycle accept is discarded.
4. Accept, with `ENTRY_EN`=1 and `DIGIT_CNT`<4: `DIGITS` ← {`DIGITS`[11:0], `bcd_q`}, `DIGIT_CNT`++, `KEY_ACK`=1.
   - Accept with `ENTRY_EN`=0 or `DIGIT_CNT`=4: ignored, with no `KEY_ACK`.
- A leading 0 is shifted in and counts as a digit.
- `BCD` > 9 at acceptance is ignored (no shift, no `KEY_ACK`).
- `START` held high produces a pulse every cycle. Level-to-pulse conversion is the controller's job.

## Timing
- Reset values:
  - `DIGITS`=16'h0000, `DIGIT_CNT`=0, `KEY_ACK`=0, `LOAD_TIMER`=0, `ERR`=0.
  - Key FSM = IDLE, `cnt`=0.
- `RST` asserted mid-debounce or mid-hold:
  - FSM returns to IDLE.
  - A key still held after `RST` deasserts is treated as a new press.
- Press latency:
  - `LOAD_N` is sampled low at edges k..k+N−1, with N=`DEBOUNCE_CYCLES`.
  - The shift happens at edge k+N−1; `DIGITS` and `KEY_ACK` are visible after that edge.
  - `KEY_ACK` deasserts after the next edge.
- Release: N consecutive high samples are needed before IDLE. The earliest next accept is edge (release start)+N+N−1.
- `LOAD_TIMER` and `ERR` are registered, visible the cycle after `START` is sampled.
- `VALID` is combinational from the registered `DIGITS`, so it updates in the same cycle as `DIGITS`.

## Test plan
- Basic entry, `DEBOUNCE_CYCLES`=4: press 1, 3, 0 (each low 6 cycles, high 6 cycles) → `DIGITS`=16'h0130, `DIGIT_CNT`=3, three `KEY_ACK` pulses, each 4 edges after `LOAD_N` falls.
- Bounce: `LOAD_N` low 2 cycles, high 1, low 6 with `BCD`=5 → exactly one accept of 5. A bounce of ≤3 cycles during release produces no second accept.
- Overflow and clear: press 1, 2, 3, 4, 5 → `DIGITS`=16'h1234, `DIGIT_CNT`=4, with no fifth `KEY_ACK`. Then `CLEAR` → 16'h0000, `DIGIT_CNT`=0.
- Validation:
  - Enter 1, 7, 5 (0x0175), then `START` → `ERR` pulse, no `LOAD_TIMER`.
  - Enter 1, 3, 0 (0x0130), then `START` → `LOAD_TIMER` pulse, `DIGITS` still 0x0130.
  - `START` with `DIGITS`=0 → `ERR`.
- Simultaneous events:
  - Accept coincident with `CLEAR` → `DIGITS`=0, no `KEY_ACK`.
  - Accept coincident with `START` → timer loads the pre-shift value, digit dropped.
  - Accept with `ENTRY_EN`=0 → no change.
- Reset mid-operation: `RST` during DEBOUNCE with key still held → all outputs at reset values. After `RST` falls, the held key is accepted 4 edges later.
